// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounced press/release detection.
// Each accepted key produces one write strobe; each completed release advances the digit index.
module keypad_entry #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] num,
  output logic [2:0] sel,
  output logic       write,
  output logic       pressed
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  logic [3:0]       sync1_q, sync2_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic             cand_vld_q, cand_vld_d;
  logic [3:0]       cand_key_q, cand_key_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_q, key_d;
  logic [3:0]       num_q, num_d;
  logic [2:0]       sel_q, sel_d;
  logic             write_q, write_d;
  logic             inc_q, inc_d;

  logic             tick;
  logic             scan_end;
  logic             row_hit;
  logic [1:0]       row_idx;
  logic             res_vld;
  logic [3:0]       res_key;
  logic [CNT_W-1:0] cnt_inc;

  assign tick     = (div_q == DIV_LAST);
  assign scan_end = tick && (col_q == 2'd3);
  assign cnt_inc  = cnt_q + 1'b1;

  // Lowest-numbered low row wins within the active column.
  always_comb begin
    row_hit = 1'b0;
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!sync2_q[r]) begin
        row_hit = 1'b1;
        row_idx = 2'(r);
      end
    end
  end

  // res_* is the scan result including the current column's sample; column 0 starts fresh.
  always_comb begin
    div_d      = tick ? '0 : div_q + 1'b1;
    col_d      = tick ? col_q + 2'd1 : col_q;
    cand_vld_d = cand_vld_q;
    cand_key_d = cand_key_q;
    res_vld    = cand_vld_q;
    res_key    = cand_key_q;
    if (col_q == 2'd0) begin
      res_vld = 1'b0;
      res_key = 4'd0;
    end
    if (!res_vld && row_hit) begin
      res_vld = 1'b1;
      res_key = {row_idx, col_q};
    end
    if (tick) begin
      cand_vld_d = res_vld;
      cand_key_d = res_key;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    num_d   = num_q;
    write_d = 1'b0;
    inc_d   = 1'b0;
    sel_d   = inc_q ? sel_q + 3'd1 : sel_q;
    if (scan_end) begin
      case (state_q)
        IDLE: begin
          if (res_vld) begin
            key_d = res_key;
            cnt_d = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              state_d = HELD;
              num_d   = res_key;
              write_d = 1'b1;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (res_vld && (res_key == key_q)) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_d = HELD;
              num_d   = key_q;
              write_d = 1'b1;
            end
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (!res_vld) begin
            cnt_d = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              state_d = IDLE;
              inc_d   = 1'b1;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (!res_vld) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_LAST) begin
              state_d = IDLE;
              inc_d   = 1'b1;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 4'hF;
      sync2_q    <= 4'hF;
      div_q      <= '0;
      col_q      <= 2'd0;
      cand_vld_q <= 1'b0;
      cand_key_q <= 4'd0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      key_q      <= 4'd0;
      num_q      <= 4'd0;
      sel_q      <= 3'd0;
      write_q    <= 1'b0;
      inc_q      <= 1'b0;
    end else begin
      sync1_q    <= rows;
      sync2_q    <= sync1_q;
      div_q      <= div_d;
      col_q      <= col_d;
      cand_vld_q <= cand_vld_d;
      cand_key_q <= cand_key_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      num_q      <= num_d;
      sel_q      <= sel_d;
      write_q    <= write_d;
      inc_q      <= inc_d;
    end
  end

  assign cols    = ~(4'b0001 << col_q);
  assign num     = num_q;
  assign sel     = sel_q;
  assign write   = write_q;
  assign pressed = (state_q == HELD) || (state_q == RELEASE);

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: simulated key matrix, per-scan directed table, reset corners
// and random key traffic checked cycle by cycle against a scan-level reference model.
module tb_keypad_entry;

  localparam int SD   = 8;
  localparam int DS   = 3;
  localparam int SCAN = 4 * SD;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] num;
  logic [2:0] sel;
  logic       write;
  logic       pressed;

  logic [15:0] keys = 16'h0000;

  keypad_entry #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .reset(reset), .rows(rows), .cols(cols),
    .num(num), .sel(sel), .write(write), .pressed(pressed)
  );

  always #5 clk = ~clk;

  // A pressed key at (r,c) shorts row r to column c; only the low column pulls a row low.
  function automatic logic [3:0] row_drive(logic [3:0] c, logic [15:0] k);
    logic [3:0] r;
    r = 4'hF;
    for (int ri = 0; ri < 4; ri++)
      for (int ci = 0; ci < 4; ci++)
        if (!c[ci] && k[4*ri+ci]) r[ri] = 1'b0;
    return r;
  endfunction

  always_comb rows = row_drive(cols, keys);

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: works on whole-scan results and runs of consecutive scans.
  int         n = 0;
  int         m_run_key = 0;
  int         m_run_len = 0;
  int         m_clear_len = 0;
  bit         m_held = 0;
  bit         m_write = 0;
  bit         m_inc = 0;
  logic [3:0] m_num = 4'd0;
  logic [2:0] m_sel = 3'd0;

  function automatic int scan_result(logic [15:0] k);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (k[4*r+c]) return 4*r + c;
    return -1;
  endfunction

  task automatic model_accept(int key);
    m_held = 1; m_write = 1; m_num = 4'(key); m_run_len = 0; m_clear_len = 0;
  endtask

  task automatic model_scan(int res);
    if (!m_held) begin
      if (m_run_len > 0) begin
        if (res == m_run_key) begin
          m_run_len++;
          if (m_run_len == DS) model_accept(m_run_key);
        end else begin
          m_run_len = 0;
        end
      end else if (res >= 0) begin
        m_run_key = res;
        m_run_len = 1;
        if (DS == 1) model_accept(res);
      end
    end else begin
      if (res < 0) begin
        m_clear_len++;
        if (m_clear_len == DS) begin
          m_held = 0; m_inc = 1; m_clear_len = 0;
        end
      end else begin
        m_clear_len = 0;
      end
    end
  endtask

  int         obs_w = 0;
  int         obs_num = 0;
  int         obs_sel = 0;
  logic [3:0] exp_cols;

  task automatic step();
    @(posedge clk);
    #1;
    if (reset) begin
      n = 0; m_run_len = 0; m_clear_len = 0; m_held = 0; m_write = 0; m_inc = 0;
      m_num = 4'd0; m_sel = 3'd0;
    end else begin
      n++;
      m_write = 0;
      if (m_inc) begin
        m_sel = m_sel + 3'd1;
        m_inc = 0;
      end
      if (n % SCAN == 0) model_scan(scan_result(keys));
    end
    exp_cols = 4'b0001 << ((n / SD) % 4);
    exp_cols = ~exp_cols;
    chk("cols", cols, exp_cols);
    chk("write", write, m_write);
    chk("num", num, m_num);
    chk("sel", sel, m_sel);
    chk("pressed", pressed, m_held);
    if (write === 1'b1) begin
      obs_w++;
      obs_num = num;
      obs_sel = sel;
    end
  endtask

  task automatic run_scan(logic [15:0] k);
    keys = k;
    for (int i = 0; i < SCAN; i++) step();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  typedef struct {
    logic [15:0] k;
    int          w;
    int          nm;
    int          sl;
    int          p;
  } vec_t;

  vec_t       tbl[$];
  logic [15:0] mk;

  initial begin
    // bounce on key 0
    tbl.push_back('{16'h0001, 0, 0, 0, 0});
    tbl.push_back('{16'h0001, 0, 0, 0, 0});
    tbl.push_back('{16'h0000, 0, 0, 0, 0});
    tbl.push_back('{16'h0000, 0, 0, 0, 0});
    // clean press of row1/col2 (key 6)
    tbl.push_back('{16'h0040, 0, 0, 0, 0});
    tbl.push_back('{16'h0040, 0, 0, 0, 0});
    tbl.push_back('{16'h0040, 1, 6, 0, 1});
    tbl.push_back('{16'h0040, 0, 6, 0, 1});
    tbl.push_back('{16'h0040, 0, 6, 0, 1});
    tbl.push_back('{16'h0040, 0, 6, 0, 1});
    tbl.push_back('{16'h0000, 0, 6, 0, 1});
    tbl.push_back('{16'h0000, 0, 6, 0, 1});
    tbl.push_back('{16'h0000, 0, 6, 0, 0});
    tbl.push_back('{16'h0000, 0, 6, 1, 0});
    // row3/col0 and row0/col2 together: column 0 wins -> 12
    tbl.push_back('{16'h1004, 0, 6, 1, 0});
    tbl.push_back('{16'h1004, 0, 6, 1, 0});
    tbl.push_back('{16'h1004, 1, 12, 1, 1});
    tbl.push_back('{16'h1004, 0, 12, 1, 1});
    tbl.push_back('{16'h0000, 0, 12, 1, 1});
    tbl.push_back('{16'h0000, 0, 12, 1, 1});
    tbl.push_back('{16'h0000, 0, 12, 1, 0});
    tbl.push_back('{16'h0000, 0, 12, 2, 0});
    // release glitch on key 5
    tbl.push_back('{16'h0020, 0, 12, 2, 0});
    tbl.push_back('{16'h0020, 0, 12, 2, 0});
    tbl.push_back('{16'h0020, 1, 5, 2, 1});
    tbl.push_back('{16'h0000, 0, 5, 2, 1});
    tbl.push_back('{16'h0000, 0, 5, 2, 1});
    tbl.push_back('{16'h0020, 0, 5, 2, 1});
    tbl.push_back('{16'h0000, 0, 5, 2, 1});
    tbl.push_back('{16'h0000, 0, 5, 2, 1});
    tbl.push_back('{16'h0000, 0, 5, 2, 0});
    tbl.push_back('{16'h0000, 0, 5, 3, 0});
    // key change during debounce restarts from idle; key change while held is ignored
    tbl.push_back('{16'h0200, 0, 5, 3, 0});
    tbl.push_back('{16'h0400, 0, 5, 3, 0});
    tbl.push_back('{16'h0400, 0, 5, 3, 0});
    tbl.push_back('{16'h0400, 0, 5, 3, 0});
    tbl.push_back('{16'h0400, 1, 10, 3, 1});
    tbl.push_back('{16'h0800, 0, 10, 3, 1});
    tbl.push_back('{16'h0000, 0, 10, 3, 1});
    tbl.push_back('{16'h0000, 0, 10, 3, 1});
    tbl.push_back('{16'h0000, 0, 10, 3, 0});
    tbl.push_back('{16'h0000, 0, 10, 4, 0});

    apply_reset();
    chk("rst_cols", cols, 4'b1110);
    chk("rst_sel", sel, 0);
    chk("rst_num", num, 0);
    chk("rst_pressed", pressed, 0);

    foreach (tbl[i]) begin
      obs_w = 0;
      run_scan(tbl[i].k);
      $display("vec %0d keys=%h write=%0d num=%0d sel=%0d pressed=%0d",
               i, tbl[i].k, obs_w, num, sel, pressed);
      chk("tbl_writes", obs_w, tbl[i].w);
      chk("tbl_num", num, tbl[i].nm);
      chk("tbl_sel", sel, tbl[i].sl);
      chk("tbl_pressed", pressed, tbl[i].p);
    end

    // nine clean presses: sel wraps 7 -> 0
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      obs_w = 0;
      for (int s = 0; s < DS; s++) run_scan(16'h0001 << i);
      for (int s = 0; s < DS; s++) run_scan(16'h0000);
      $display("wrap press %0d writes=%0d num=%0d sel=%0d", i, obs_w, obs_num, obs_sel);
      chk("wrap_writes", obs_w, 1);
      chk("wrap_num", obs_num, i);
      chk("wrap_sel", obs_sel, i % 8);
    end

    // reset while held: state cleared, held key re-accepted at sel 0
    apply_reset();
    obs_w = 0;
    for (int s = 0; s < DS; s++) run_scan(16'h0080);
    chk("held_pre_write", obs_w, 1);
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    $display("reset in held: sel=%0d num=%0d pressed=%0d cols=%b write=%0d",
             sel, num, pressed, cols, write);
    chk("held_rst_sel", sel, 0);
    chk("held_rst_num", num, 0);
    chk("held_rst_pressed", pressed, 0);
    chk("held_rst_cols", cols, 4'b1110);
    chk("held_rst_write", write, 0);
    obs_w = 0;
    for (int s = 0; s < DS; s++) run_scan(16'h0080);
    chk("held_reaccept_writes", obs_w, 1);
    chk("held_reaccept_num", obs_num, 7);
    chk("held_reaccept_sel", obs_sel, 0);

    // reset on the very edge that would accept: no strobe may follow
    apply_reset();
    obs_w = 0;
    keys = 16'h0008;
    for (int s = 0; s < DS - 1; s++) run_scan(16'h0008);
    for (int i = 0; i < SCAN - 1; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    $display("reset at accept edge: writes=%0d pressed=%0d", obs_w, pressed);
    chk("acc_rst_writes", obs_w, 0);
    chk("acc_rst_pressed", pressed, 0);
    for (int i = 0; i < SCAN - 1; i++) step();
    for (int s = 0; s < DS - 1; s++) run_scan(16'h0008);
    chk("acc_rst_reaccept_writes", obs_w, 1);
    chk("acc_rst_reaccept_num", obs_num, 3);

    // random key traffic against the model
    apply_reset();
    mk = 16'h0000;
    for (int s = 0; s < 80; s++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: mk = mk;
        4, 5, 6:    mk = 16'h0000;
        7, 8:       mk = 16'h0001 << $urandom_range(0, 15);
        default:    mk = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      endcase
      obs_w = 0;
      run_scan(mk);
      $display("rand scan %0d keys=%h write=%0d num=%0d sel=%0d pressed=%0d",
               s, mk, obs_w, num, sel, pressed);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
